// File: rtl/buzz_pkg.sv
// Shared level and channel-state encodings for the buzzer driver, plus
// helpers that size counters from their parameter values.
package buzz_pkg;

    localparam logic [1:0] LVL_OFF  = 2'd0;
    localparam logic [1:0] LVL_SLOW = 2'd1;
    localparam logic [1:0] LVL_FAST = 2'd2;
    localparam logic [1:0] LVL_CONT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } chan_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed for a counter that wraps at n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buzz_channel.sv
// One buzzer channel: beep cadence FSM driven by the shared tick, plus a
// tone divider that only runs while the beep is ON.
module buzz_channel
    import buzz_pkg::*;
#(
    parameter int TONE_DIV = 12500,
    parameter int ON_TICKS = 100,
    parameter int OFF_SLOW = 400,
    parameter int OFF_FAST = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] buzz,
    output logic       tone,
    output logic       active
);

    localparam int CW = cnt_width(max3(ON_TICKS, OFF_SLOW, OFF_FAST));
    localparam int TW = cnt_width(TONE_DIV);
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(OFF_SLOW - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(OFF_FAST - 1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

    chan_state_t   state_r, state_s;
    logic [1:0]    level_r, level_s;
    logic [CW-1:0] cad_r, cad_s, off_last_s;
    logic [TW-1:0] tone_cnt_r, tone_cnt_s;
    logic          tone_q_r, tone_q_s;
    logic          active_r, tone_r;

    // Cadence next-state: escalation overrides everything, else walk the beep.
    always_comb begin
        state_s = state_r;
        level_s = level_r;
        cad_s   = cad_r;
        if (level_r == LVL_SLOW) begin
            off_last_s = SLOW_LAST;
        end else begin
            off_last_s = FAST_LAST;
        end
        if (buzz > level_r) begin
            state_s = ST_ON;
            cad_s   = {CW{1'b0}};
            level_s = buzz;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ON: begin
                    if (level_r == LVL_CONT) begin
                        if (buzz == LVL_CONT) begin
                            state_s = ST_ON;
                        end else if (buzz == LVL_OFF) begin
                            state_s = ST_IDLE;
                            level_s = LVL_OFF;
                            cad_s   = {CW{1'b0}};
                        end else begin
                            state_s = ST_OFF;
                            level_s = buzz;
                            cad_s   = {CW{1'b0}};
                        end
                    end else if (tick) begin
                        if (cad_r == ON_LAST) begin
                            state_s = ST_OFF;
                            cad_s   = {CW{1'b0}};
                        end else begin
                            cad_s = cad_r + CW'(1'b1);
                        end
                    end else begin
                        cad_s = cad_r;
                    end
                end
                ST_OFF: begin
                    if (tick) begin
                        if (cad_r == off_last_s) begin
                            // Period end: the requested level is adopted only here.
                            level_s = buzz;
                            cad_s   = {CW{1'b0}};
                            if (buzz == LVL_OFF) begin
                                state_s = ST_IDLE;
                            end else begin
                                state_s = ST_ON;
                            end
                        end else begin
                            cad_s = cad_r + CW'(1'b1);
                        end
                    end else begin
                        cad_s = cad_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    level_s = LVL_OFF;
                    cad_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // Tone divider: advances only while staying ON, otherwise parked at zero.
    always_comb begin
        tone_cnt_s = {TW{1'b0}};
        tone_q_s   = 1'b0;
        if ((state_r == ST_ON) && (state_s == ST_ON)) begin
            if (tone_cnt_r == TONE_LAST) begin
                tone_cnt_s = {TW{1'b0}};
                tone_q_s   = ~tone_q_r;
            end else begin
                tone_cnt_s = tone_cnt_r + TW'(1'b1);
                tone_q_s   = tone_q_r;
            end
        end else begin
            tone_cnt_s = {TW{1'b0}};
            tone_q_s   = 1'b0;
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            level_r    <= LVL_OFF;
            cad_r      <= {CW{1'b0}};
            tone_cnt_r <= {TW{1'b0}};
            tone_q_r   <= 1'b0;
            active_r   <= 1'b0;
            tone_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            level_r    <= level_s;
            cad_r      <= cad_s;
            tone_cnt_r <= tone_cnt_s;
            tone_q_r   <= tone_q_s;
            active_r   <= (state_s == ST_ON);
            tone_r     <= tone_q_s & (state_s == ST_ON);
        end
    end

    assign active = active_r;
    assign tone   = tone_r;

endmodule

// File: rtl/buzzer_driver.sv
// Two-channel piezo buzzer driver: a shared cadence-tick prescaler feeding
// independent left and right beep/tone channels.
module buzzer_driver
    import buzz_pkg::*;
#(
    parameter int TICK_DIV   = 10000,
    parameter int TONE_DIV_L = 12500,
    parameter int TONE_DIV_R = 10000,
    parameter int ON_TICKS   = 100,
    parameter int OFF_SLOW   = 400,
    parameter int OFF_FAST   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] left_buzz,
    input  logic [1:0] right_buzz,
    output logic       left_tone,
    output logic       right_tone,
    output logic       left_active,
    output logic       right_active
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_r;
    logic          tick_s;

    // Free-running prescaler; never restarted by channel activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_r <= {PW{1'b0}};
        end else if (pre_r == PRE_LAST) begin
            pre_r <= {PW{1'b0}};
        end else begin
            pre_r <= pre_r + PW'(1'b1);
        end
    end

    assign tick_s = (pre_r == PRE_LAST);

    buzz_channel #(
        .TONE_DIV (TONE_DIV_L),
        .ON_TICKS (ON_TICKS),
        .OFF_SLOW (OFF_SLOW),
        .OFF_FAST (OFF_FAST)
    ) u_left (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick_s),
        .buzz   (left_buzz),
        .tone   (left_tone),
        .active (left_active)
    );

    buzz_channel #(
        .TONE_DIV (TONE_DIV_R),
        .ON_TICKS (ON_TICKS),
        .OFF_SLOW (OFF_SLOW),
        .OFF_FAST (OFF_FAST)
    ) u_right (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick_s),
        .buzz   (right_buzz),
        .tone   (right_tone),
        .active (right_active)
    );

endmodule
